ahb_burst_sequencer: RTL
========================

Name: ahb_burst_sequencer

Overview:
AHB manager-side address/control sequencer. Accepts one burst command per handshake and drives HTRANS/HADDR/HBURST/HSIZE/HWRITE beat by beat, honouring HREADY wait states and the two-cycle HRESP ERROR response. Tracks the pipelined data phase and tells the manager's data path which beat is in flight. Sits between the manager driver/BFM and the AHB interface.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width in bits (8..1024, power of 2)
LEN_WIDTH, 8, width of the beat-count field for undefined-length INCR

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_addr  in  ADDR_WIDTH  start address
cmd_burst  in  3  burst encoding: SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
cmd_size  in  3  HSIZE encoding: BYTE..LINE32
cmd_write  in  1  1 = write
cmd_len  in  LEN_WIDTH  beats for INCR; 0 is treated as 1; ignored for other bursts
haddr  out  ADDR_WIDTH  address phase address
htrans  out  2  IDLE=00, BUSY=01 (never driven), NONSEQ=10, SEQ=11
hburst  out  3  burst of the current command
hsize  out  3  size of the current command
hwrite  out  1  direction of the current command
hready  in  1  combined transfer ready
hresp  in  1  0 = OKAY, 1 = ERROR
dphase_valid  out  1  data phase in flight this cycle
dphase_beat  out  LEN_WIDTH  index of the beat in its data phase
cmd_done  out  1  one-cycle pulse at burst completion
cmd_err  out  1  qualifies cmd_done: burst ended in error or was rejected

Behaviour:
- Reset (async, hresetn=0): state IDLE; htrans=IDLE; haddr, hburst, hsize, hwrite, dphase_valid, dphase_beat, cmd_done, cmd_err = 0; cmd_ready=1. Reset mid-burst aborts immediately; htrans goes IDLE with no completion pulse.
- States: IDLE, ADDR, LAST_DATA, ERR_WAIT.
- cmd_ready = (state==IDLE). On acceptance edge E0: latch command; beat count N = 1 (SINGLE), max(cmd_len,1) (INCR), 4/8/16 (fixed bursts). From E0: htrans=NONSEQ, haddr=cmd_addr; state ADDR.
- Reject: if (8<<cmd_size) > DATA_WIDTH, no bus activity. cmd_done=cmd_err=1 for one cycle from E0, then remain in IDLE.
- ADDR: outputs hold while hready=0. At an edge with hready=1, the current address is accepted. That beat becomes the data phase (dphase_valid=1, dphase_beat=beat). If more beats remain, drive the next address with htrans=SEQ. After the last address is accepted: htrans=IDLE, state LAST_DATA.
- Address step = 1<<hsize bytes. INCR types: addr+step, truncated to ADDR_WIDTH. WRAP types: boundary B=N*step; next = (addr & ~(B-1)) | ((addr+step) & (B-1)).
- LAST_DATA: at an edge with hready=1 and hresp=0, assert cmd_done=1, cmd_err=0 for one cycle; dphase_valid=0; state IDLE (cmd_ready=1 that same cycle).
- Error: in any data phase, hresp=1 with hready=0 (first error cycle) causes htrans=IDLE from the next edge and cancels all remaining beats; state ERR_WAIT. At the edge with hready=1 (second cycle), assert cmd_done=cmd_err=1 and go to IDLE. hresp=1 with hready=1 and no preceding low-ready cycle is a protocol violation; treat it as an error completion the same way.
- Zero-wait INCR4 timing: NONSEQ at E0, SEQ at E1–E3, IDLE at E4; cmd_done in the cycle following E5.

Optional Feature:
AHB_BURST_1KB_SPLIT_EN. When defined, for INCR-type bursts, a beat whose address crosses a 1 KB boundary (addr[9:0] wraps to 0) is issued as NONSEQ instead of SEQ. That forces hburst=INCR for the remainder of the command. Without the macro, the address increments linearly with SEQ, and the caller guarantees that no burst crosses 1 KB.

Test Plan:
- INCR4 write, addr 0x100, WORD, hready=1 -> haddr 0x100/104/108/10C; htrans NONSEQ,SEQ,SEQ,SEQ,IDLE; cmd_done=1, cmd_err=0 five edges after accept.
- WRAP4 read, addr 0x38, WORD -> haddr 0x38,0x3C,0x30,0x34; dphase_beat 0..3 each one cycle behind.
- INCR8 with hready=0 for 2 cycles during beat 2 address -> haddr/htrans held stable; burst completes 2 cycles late; all 8 beats issued.
- INCR8, hresp ERROR (hready 0 then 1) in beat 2 data phase -> htrans=IDLE next cycle; beats 4..7 never issued; cmd_done=cmd_err=1.
- cmd_size=DOUBLEWORD with DATA_WIDTH=32 -> htrans stays IDLE; cmd_done=cmd_err=1 one cycle after accept. INCR cmd_len=0 -> single NONSEQ beat.
- With AHB_BURST_1KB_SPLIT_EN: INCR cmd_len=3, addr 0x3FC, WORD -> 0x3FC NONSEQ, 0x400 NONSEQ, 0x404 SEQ. hresetn pulsed mid-burst -> htrans IDLE immediately, cmd_ready=1, no cmd_done.

Source files
------------

// File: rtl/ahb_burst_sequencer.sv
// AHB manager address/control sequencer: one burst per command, pipelined data-phase tracking.
// Optional: define AHB_BURST_1KB_SPLIT_EN to reissue INCR beats crossing a 1 KB boundary as NONSEQ.
module ahb_burst_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic                  cmd_write,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic [2:0]            hburst,
  output logic [2:0]            hsize,
  output logic                  hwrite,
  input  logic                  hready,
  input  logic                  hresp,
  output logic                  dphase_valid,
  output logic [LEN_WIDTH-1:0]  dphase_beat,
  output logic                  cmd_done,
  output logic                  cmd_err
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR = 3'b001;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST_DATA, ST_ERR_WAIT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [2:0]            hburst_q, hburst_d;
  logic [2:0]            hsize_q, hsize_d;
  logic                  hwrite_q, hwrite_d;
  logic                  dval_q, dval_d;
  logic [LEN_WIDTH-1:0]  dbeat_q, dbeat_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  last_q, last_d;
  logic                  wrap_q, wrap_d;

  logic                  reject_c;
  logic [LEN_WIDTH-1:0]  last_c;
  logic [ADDR_WIDTH-1:0] step_c, inc_c, wmask_c, next_c;
  logic                  split_c;

  // Transfer wider than the data bus cannot be issued.
  assign reject_c = (32'd8 << cmd_size) > DATA_WIDTH;

  // Index of the final beat of the offered command.
  always_comb begin
    case (cmd_burst)
      3'b000:        last_c = '0;
      3'b001:        last_c = (cmd_len == '0) ? '0 : cmd_len - LEN_WIDTH'(1);
      3'b010, 3'b011: last_c = LEN_WIDTH'(3);
      3'b100, 3'b101: last_c = LEN_WIDTH'(7);
      default:       last_c = LEN_WIDTH'(15);
    endcase
  end

  // Wrap mask is (beats * step) - 1; only the bits under it advance for WRAP bursts.
  assign step_c  = ADDR_WIDTH'(1) << hsize_q;
  assign inc_c   = haddr_q + step_c;
  assign wmask_c = ((ADDR_WIDTH'(last_q) + ADDR_WIDTH'(1)) << hsize_q) - ADDR_WIDTH'(1);
  assign next_c  = wrap_q ? ((haddr_q & ~wmask_c) | (inc_c & wmask_c)) : inc_c;

`ifdef AHB_BURST_1KB_SPLIT_EN
  assign split_c = hburst_q[0] && (next_c[9:0] == 10'd0);
`else
  assign split_c = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      htrans_q <= TR_IDLE;
      hburst_q <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      dval_q   <= 1'b0;
      dbeat_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      beat_q   <= '0;
      last_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      dval_q   <= dval_d;
      dbeat_q  <= dbeat_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hburst_d = hburst_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    dval_d   = dval_q;
    dbeat_d  = dbeat_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    beat_d   = beat_q;
    last_d   = last_q;
    wrap_d   = wrap_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (reject_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            haddr_d  = cmd_addr;
            htrans_d = TR_NONSEQ;
            hburst_d = cmd_burst;
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            beat_d   = '0;
            last_d   = last_c;
            wrap_d   = (cmd_burst != 3'b000) && !cmd_burst[0];
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (dval_q && hresp) begin
          // Error on the previous beat cancels everything still queued.
          htrans_d = TR_IDLE;
          if (hready) begin
            dval_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERR_WAIT;
          end
        end else if (hready) begin
          dval_d  = 1'b1;
          dbeat_d = beat_q;
          if (beat_q == last_q) begin
            htrans_d = TR_IDLE;
            state_d  = ST_LAST_DATA;
          end else begin
            beat_d   = beat_q + LEN_WIDTH'(1);
            haddr_d  = next_c;
            htrans_d = split_c ? TR_NONSEQ : TR_SEQ;
            if (split_c) hburst_d = BURST_INCR;
          end
        end
      end
      ST_LAST_DATA: begin
        if (hresp) begin
          if (hready) begin
            dval_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERR_WAIT;
          end
        end else if (hready) begin
          dval_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR_WAIT: begin
        if (hready) begin
          dval_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  assign cmd_ready    = ready_q;
  assign haddr        = haddr_q;
  assign htrans       = htrans_q;
  assign hburst       = hburst_q;
  assign hsize        = hsize_q;
  assign hwrite       = hwrite_q;
  assign dphase_valid = dval_q;
  assign dphase_beat  = dbeat_q;
  assign cmd_done     = done_q;
  assign cmd_err      = err_q;

endmodule
